// File: rtl/topk_stream_select.sv
// Streaming top-K selector: keeps the K smallest (distance, global index) pairs
// seen across a multi-beat frame and presents them sorted when the frame ends.
module topk_stream_select #(
    parameter int Bit   = 8,
    parameter int K     = 2,
    parameter int LANES = 8,
    parameter int IDX_W = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [LANES-1:0][Bit-1:0]   in_dist,
    input  logic [LANES-1:0]            in_mask,
    input  logic                        in_last,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [K-1:0][Bit-1:0]       out_dist,
    output logic [K-1:0][IDX_W-1:0]     out_addr,
    output logic [$clog2(K+1)-1:0]      out_count,
    output logic                        out_ovf
);

    localparam int CNT_W = $clog2(K+1);

    typedef struct packed {
        logic             v;
        logic [Bit-1:0]   d;
        logic [IDX_W-1:0] i;
    } entry_t;

    typedef entry_t [K-1:0] list_t;

    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Strict total order on (dist, index); invalid entries rank above all valid ones.
    function automatic logic ranks_below(entry_t a, entry_t b);
        logic r;
        if (!a.v) begin
            r = 1'b0;
        end else if (!b.v) begin
            r = 1'b1;
        end else if (a.d != b.d) begin
            r = (a.d < b.d);
        end else begin
            r = (a.i < b.i);
        end
        return r;
    endfunction

    // Sorted insertion: entries past the insertion point shift down, the last drops off.
    function automatic list_t insert_entry(list_t l, entry_t c);
        list_t          r;
        logic [K-1:0]   lt;
        for (int j = 0; j < K; j++) begin
            lt[j] = ranks_below(c, l[j]);
        end
        r[0] = lt[0] ? c : l[0];
        for (int j = 1; j < K; j++) begin
            if (!lt[j]) begin
                r[j] = l[j];
            end else if (!lt[j-1]) begin
                r[j] = c;
            end else begin
                r[j] = l[j-1];
            end
        end
        return r;
    endfunction

    function automatic logic [CNT_W-1:0] count_valid(list_t l);
        logic [CNT_W-1:0] n;
        n = '0;
        for (int j = 0; j < K; j++) begin
            if (l[j].v) begin
                n = n + CNT_W'(1);
            end else begin
                n = n;
            end
        end
        return n;
    endfunction

    state_t                     state_q, state_d;
    logic                       in_ready_q;
    logic [IDX_W-1:0]           base_q;
    logic                       ovf_q;
    logic                       s1_valid_q, s1_last_q;
    list_t                      s1_list_q, s1_list_d;
    list_t                      list_q, merged_s;
    logic                       mrg_last_q;
    logic                       out_valid_q;
    logic [K-1:0][Bit-1:0]      out_dist_q, out_dist_d;
    logic [K-1:0][IDX_W-1:0]    out_addr_q, out_addr_d;
    logic [CNT_W-1:0]           out_count_q;
    logic                       out_ovf_q;

    logic                       accept_s;
    logic                       load_out_s;
    logic                       clear_s;
    logic [IDX_W:0]             base_sum_s;

    assign accept_s   = in_valid & in_ready_q;
    // A carry out of the beat base means the next beat's indices wrap.
    assign base_sum_s = {1'b0, base_q} + (IDX_W+1)'(LANES);

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_dist  = out_dist_q;
    assign out_addr  = out_addr_q;
    assign out_count = out_count_q;
    assign out_ovf   = out_ovf_q;

    // Frame sequencing: accumulate, wait for the pipeline to empty, hold result.
    always_comb begin
        state_d    = state_q;
        load_out_s = 1'b0;
        clear_s    = 1'b0;
        case (state_q)
            ACCUM: begin
                if (accept_s && in_last) begin
                    state_d = DRAIN;
                end else begin
                    state_d = ACCUM;
                end
            end
            DRAIN: begin
                if (mrg_last_q) begin
                    state_d    = DONE;
                    load_out_s = 1'b1;
                end else begin
                    state_d = DRAIN;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = ACCUM;
                    clear_s = 1'b1;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = ACCUM;
            end
        endcase
    end

    // State register; in_ready is registered from the next state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ACCUM;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d == ACCUM);
        end
    end

    // Beat base index and sticky overflow for the current frame.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            base_q <= '0;
            ovf_q  <= 1'b0;
        end else if (clear_s) begin
            base_q <= '0;
            ovf_q  <= 1'b0;
        end else if (accept_s) begin
            base_q <= base_sum_s[IDX_W-1:0];
            ovf_q  <= ovf_q | (base_sum_s[IDX_W] & ~in_last);
        end else begin
            base_q <= base_q;
            ovf_q  <= ovf_q;
        end
    end

    // Stage 1 selection: insert each unmasked lane into an initially empty list.
    always_comb begin
        s1_list_d = '0;
        for (int l = 0; l < LANES; l++) begin
            s1_list_d = insert_entry(s1_list_d,
                                     entry_t'({in_mask[l], in_dist[l], base_q + IDX_W'(l)}));
        end
    end

    // Stage 1 registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid_q <= 1'b0;
            s1_last_q  <= 1'b0;
            s1_list_q  <= '0;
        end else begin
            s1_valid_q <= accept_s;
            s1_last_q  <= accept_s & in_last;
            s1_list_q  <= accept_s ? s1_list_d : s1_list_q;
        end
    end

    // Stage 2 merge of the beat's candidates into the running list.
    always_comb begin
        merged_s = list_q;
        for (int j = 0; j < K; j++) begin
            merged_s = insert_entry(merged_s, s1_list_q[j]);
        end
    end

    // Running list and the flag marking that the final beat has been merged.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            list_q     <= '0;
            mrg_last_q <= 1'b0;
        end else begin
            if (clear_s) begin
                list_q <= '0;
            end else if (s1_valid_q) begin
                list_q <= merged_s;
            end else begin
                list_q <= list_q;
            end
            if (load_out_s) begin
                mrg_last_q <= 1'b0;
            end else if (s1_valid_q && s1_last_q) begin
                mrg_last_q <= 1'b1;
            end else begin
                mrg_last_q <= mrg_last_q;
            end
        end
    end

    // Unused result slots read as all-ones distance and index zero.
    always_comb begin
        out_dist_d = '1;
        out_addr_d = '0;
        for (int j = 0; j < K; j++) begin
            out_dist_d[j] = list_q[j].v ? list_q[j].d : {Bit{1'b1}};
            out_addr_d[j] = list_q[j].v ? list_q[j].i : {IDX_W{1'b0}};
        end
    end

    // Result registers, held stable for the whole DONE state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_q <= 1'b0;
            out_dist_q  <= '1;
            out_addr_q  <= '0;
            out_count_q <= '0;
            out_ovf_q   <= 1'b0;
        end else if (load_out_s) begin
            out_valid_q <= 1'b1;
            out_dist_q  <= out_dist_d;
            out_addr_q  <= out_addr_d;
            out_count_q <= count_valid(list_q);
            out_ovf_q   <= ovf_q;
        end else if (clear_s) begin
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= out_valid_q;
        end
    end

endmodule

// File: tb/tb_topk_stream_select.sv
// Scoreboard bench for topk_stream_select: a reference model predicts each frame's
// result when its last beat is driven; the monitor compares on each output handshake.
module tb_topk_stream_select;

    localparam int LANES = 8;
    localparam int K     = 2;

    typedef logic [LANES-1:0][7:0] beat_t;
    typedef struct {
        logic [K-1:0][7:0] d;
        logic [K-1:0][7:0] a;
        int                cnt;
        logic              ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;

    logic              in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b1;
    logic              in_ready, out_valid, out_ovf;
    beat_t             in_dist = '0;
    logic [LANES-1:0]  in_mask = '0;
    logic [K-1:0][7:0] out_dist, out_addr;
    logic [1:0]        out_count;

    logic              o_in_valid = 1'b0, o_in_last = 1'b0, o_out_ready = 1'b1;
    logic              o_in_ready, o_out_valid, o_out_ovf;
    beat_t             o_in_dist = '0;
    logic [LANES-1:0]  o_in_mask = '0;
    logic [K-1:0][7:0] o_out_dist;
    logic [K-1:0][3:0] o_out_addr;
    logic [1:0]        o_out_count;

    int total = 0;
    int bad   = 0;

    exp_t sb_q[$];
    exp_t mon_e;
    int   fd[$];
    int   fa[$];
    int   frame_beats = 0;

    always #5 clk = ~clk;

    topk_stream_select #(.Bit(8), .K(K), .LANES(LANES), .IDX_W(8)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_dist(in_dist),
        .in_mask(in_mask), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_dist(out_dist),
        .out_addr(out_addr), .out_count(out_count), .out_ovf(out_ovf)
    );

    topk_stream_select #(.Bit(8), .K(K), .LANES(LANES), .IDX_W(4)) dut_ovf (
        .clk(clk), .rst(rst),
        .in_valid(o_in_valid), .in_ready(o_in_ready), .in_dist(o_in_dist),
        .in_mask(o_in_mask), .in_last(o_in_last),
        .out_valid(o_out_valid), .out_ready(o_out_ready), .out_dist(o_out_dist),
        .out_addr(o_out_addr), .out_count(o_out_count), .out_ovf(o_out_ovf)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: pick the K smallest (dist, index) pairs of the whole frame.
    task automatic model_finish();
        exp_t e;
        int   used[$];
        int   best;
        e.cnt = 0;
        e.ovf = (frame_beats > 256 / LANES);
        for (int i = 0; i < fd.size(); i++) used.push_back(0);
        for (int j = 0; j < K; j++) begin
            best = -1;
            for (int i = 0; i < fd.size(); i++) begin
                if (used[i] == 0 && (best < 0 || fd[i] < fd[best] ||
                    (fd[i] == fd[best] && fa[i] < fa[best]))) best = i;
            end
            if (best >= 0) begin
                used[best] = 1;
                e.d[j] = 8'(fd[best]);
                e.a[j] = 8'(fa[best]);
                e.cnt++;
            end else begin
                e.d[j] = 8'hFF;
                e.a[j] = 8'h00;
            end
        end
        sb_q.push_back(e);
        fd = {};
        fa = {};
        frame_beats = 0;
    endtask

    task automatic send_beat(input beat_t d, input logic [LANES-1:0] m, input logic last);
        int n;
        n = 0;
        in_dist  = d;
        in_mask  = m;
        in_last  = last;
        in_valid = 1'b1;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) check_eq("ready_timeout", in_ready, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        for (int l = 0; l < LANES; l++) begin
            if (m[l]) begin
                fd.push_back(int'(d[l]));
                fa.push_back((frame_beats * LANES + l) % 256);
            end
        end
        frame_beats++;
        if (last) model_finish();
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((sb_q.size() != 0 || !in_ready) && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq("drain_timeout", sb_q.size(), 0);
    endtask

    function automatic beat_t rand_beat(input int maxv);
        beat_t b;
        for (int l = 0; l < LANES; l++) b[l] = 8'($urandom_range(0, maxv));
        return b;
    endfunction

    // Single beat {9,3,7,3,12,1,5,8}: result {1,3} at {5,1}, exactly two edges after accept.
    task automatic run_first_frame();
        beat_t b;
        b[0] = 8'd9; b[1] = 8'd3; b[2] = 8'd7;  b[3] = 8'd3;
        b[4] = 8'd12; b[5] = 8'd1; b[6] = 8'd5; b[7] = 8'd8;
        send_beat(b, 8'hFF, 1'b1);
        check_eq("lat_e0", out_valid, 1'b0);
        check_eq("ready_drop", in_ready, 1'b0);
        @(posedge clk); #1;
        check_eq("lat_e1", out_valid, 1'b0);
        @(posedge clk); #1;
        check_eq("lat_e2", out_valid, 1'b1);
        check_eq("s1_dist0", out_dist[0], 8'd1);
        check_eq("s1_dist1", out_dist[1], 8'd3);
        check_eq("s1_addr0", out_addr[0], 8'd5);
        check_eq("s1_addr1", out_addr[1], 8'd1);
        check_eq("s1_count", out_count, 2'd2);
        wait_idle();
    endtask

    // Monitor: any output must be predicted; compare on handshake.
    always @(negedge clk) begin
        if (rst && out_valid) begin
            if (sb_q.size() == 0) begin
                check_eq("spurious_out", out_valid, 1'b0);
            end else if (out_ready) begin
                mon_e = sb_q.pop_front();
                check_eq("sb_dist", out_dist, mon_e.d);
                check_eq("sb_addr", out_addr, mon_e.a);
                check_eq("sb_count", out_count, mon_e.cnt);
                check_eq("sb_ovf", out_ovf, mon_e.ovf);
            end
        end
    end

    initial begin
        beat_t b;
        int    n;
        int    nb;

        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        check_eq("rst_valid", out_valid, 1'b0);
        check_eq("rst_ready", in_ready, 1'b1);
        check_eq("rst_dist", out_dist, 16'hFFFF);
        check_eq("rst_addr", out_addr, 16'h0000);
        check_eq("rst_count", out_count, 2'd0);
        check_eq("rst_ovf", out_ovf, 1'b0);

        // Overflow on the IDX_W=4 instance: third beat's lane 0 wraps to index 0.
        check_eq("ovf_ready", o_in_ready, 1'b1);
        o_in_mask  = 8'hFF;
        o_in_valid = 1'b1;
        for (int bt = 0; bt < 3; bt++) begin
            for (int l = 0; l < LANES; l++) o_in_dist[l] = 8'd200;
            if (bt == 2) o_in_dist[0] = 8'd0;
            o_in_last = (bt == 2);
            @(posedge clk); #1;
        end
        o_in_valid = 1'b0;
        o_in_last  = 1'b0;
        n = 0;
        while (!o_out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq("ovf_valid", o_out_valid, 1'b1);
        check_eq("ovf_flag", o_out_ovf, 1'b1);
        check_eq("ovf_addr0", o_out_addr[0], 4'd0);
        check_eq("ovf_dist0", o_out_dist[0], 8'd0);
        check_eq("ovf_dist1", o_out_dist[1], 8'd200);
        check_eq("ovf_addr1", o_out_addr[1], 4'd0);
        check_eq("ovf_count", o_out_count, 2'd2);

        run_first_frame();

        // Tie-break across beats.
        for (int l = 0; l < LANES; l++) b[l] = 8'd4;
        send_beat(b, 8'hFF, 1'b0);
        for (int l = 0; l < LANES; l++) b[l] = 8'd9;
        b[0] = 8'd4;
        send_beat(b, 8'hFF, 1'b1);
        wait_idle();

        // Single unmasked lane, then a fully masked frame.
        b = rand_beat(255);
        b[2] = 8'd6;
        send_beat(b, 8'b0000_0100, 1'b1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check_eq("mask_count", out_count, 2'd1);
        check_eq("mask_dist0", out_dist[0], 8'd6);
        check_eq("mask_addr0", out_addr[0], 8'd2);
        check_eq("mask_dist1", out_dist[1], 8'hFF);
        check_eq("mask_addr1", out_addr[1], 8'd0);
        wait_idle();
        send_beat(rand_beat(255), 8'h00, 1'b1);
        wait_idle();
        send_beat(rand_beat(255), 8'h00, 1'b0);
        send_beat(rand_beat(15), 8'h81, 1'b1);
        wait_idle();

        // Backpressure: stall 10 cycles while junk is offered on the input.
        out_ready = 1'b0;
        send_beat(rand_beat(31), 8'hFF, 1'b0);
        send_beat(rand_beat(31), 8'h5A, 1'b1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_last  = 1'b1;
        in_mask  = 8'hFF;
        in_dist  = '0;
        for (int c = 0; c < 10; c++) begin
            check_eq("bp_valid", out_valid, 1'b1);
            check_eq("bp_ready", in_ready, 1'b0);
            check_eq("bp_dist", out_dist, sb_q[0].d);
            check_eq("bp_addr", out_addr, sb_q[0].a);
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check_eq("bp_ready_back", in_ready, 1'b1);
        run_first_frame();

        // Reset between two beats of a frame discards it.
        send_beat(rand_beat(3), 8'hFF, 1'b0);
        fd = {};
        fa = {};
        frame_beats = 0;
        rst = 1'b0;
        @(posedge clk); #1;
        check_eq("mrst_valid", out_valid, 1'b0);
        check_eq("mrst_count", out_count, 2'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        check_eq("mrst_ready", in_ready, 1'b1);
        run_first_frame();

        // Random multi-beat frames with ties and masks.
        for (int f = 0; f < 15; f++) begin
            nb = $urandom_range(1, 3);
            for (int bt = 0; bt < nb; bt++) begin
                send_beat(rand_beat(7), LANES'($urandom), bt == nb - 1);
            end
            wait_idle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/topk_stream_select.md
# topk_stream_select

Streaming, parametrised top-K nearest-distance selector for the kNN datapath. Each beat carries LANES distances from the distance units. Across a frame of one or more beats, the block keeps a running sorted list of the K smallest (distance, index) pairs and presents them as one result when the frame ends. It generalises the fixed 8-input, 2-smallest sort tree to configurable K and lane count, multi-beat frames, lane masking, deterministic tie-breaking and valid/ready flow control.

## Interface
- Bit, 8: distance width.
- K, 2: number of smallest entries reported (1..8).
- LANES, 8: distances per beat (power of 2, 2..16).
- IDX_W, 8: global index width (≥ log2(LANES)).
- clk  in  1  clock.
- rst  in  1  reset. One clock; reset is asynchronous and active-low (rst=0 resets).
- in_valid  in  1  beat valid.
- in_ready  out  1  block accepts beat.
- in_dist  in  [Bit-1:0] x LANES  lane distances.
- in_mask  in  LANES  1 = lane participates.
- in_last  in  1  final beat of frame.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_dist  out  [Bit-1:0] x K  sorted distances, entry 0 smallest.
- out_addr  out  [IDX_W-1:0] x K  global indices matching out_dist.
- out_count  out  [$clog2(K+1)-1:0]  number of valid entries.
- out_ovf  out  1  frame exceeded index space.

## Operation
- Ordering: strict total order on (dist, index). The smaller dist ranks lower. On equal dist, the lower index ranks lower. All results are deterministic.
- Global index of a lane = beat_cnt*LANES + lane. beat_cnt starts at 0 per frame and increments per accepted beat.
- Stage 1 (registered): from the accepted beat's unmasked lanes, select the K lowest pairs, sorted, each with a valid bit.
- Stage 2 (registered): merge the stage-1 candidates with the running list (K entries, each dist/index/valid). Keep the K lowest. Invalid entries rank above every valid entry.
- FSM states:
  - ACCUM: in_ready=1; beats accepted on in_valid&in_ready. An accepted beat with in_last=1 → DRAIN.
  - DRAIN: in_ready=0; wait for stage 2 to absorb the last beat, then load the output registers → DONE.
  - DONE: out_valid=1; outputs held stable until out_ready=1. On out_valid&out_ready: clear the list, beat_cnt and ovf; → ACCUM.
- out_count = number of valid list entries = min(K, unmasked lanes in frame).
- Entries at or above out_count: out_dist all ones, out_addr 0.
- Overflow: if beat_cnt wraps past 2^IDX_W/LANES beats, set sticky ovf. Indices wrap modulo 2^IDX_W; the result is still produced with out_ovf=1.
- A beat with in_mask=0 still advances beat_cnt.
- A frame whose lanes are all masked gives out_count=0.
- in_last on a fully masked beat is legal.

## Timing
- Reset (async assert, synchronous-release compatible):
  - state=ACCUM, in_ready=1 after release.
  - out_valid=0, out_dist=all ones, out_addr=0, out_count=0, out_ovf=0.
  - List invalid, beat_cnt=0, pipeline valids 0.
- Reset mid-frame or mid-DONE discards everything; no result is produced.
- Latency: last beat accepted on edge e → stage 1 at e → merge at e+1 → out_valid high after edge e+2.
- in_ready drops the cycle after in_last is accepted. It returns high the cycle after the out handshake.
- Throughput: one beat per cycle in ACCUM, no bubbles. Back-to-back frames are separated by 3 cycles plus the output stall.
- While out_valid=1 and out_ready=0, all out_* are stable.
- in_* are ignored when in_ready=0.

## Test plan
- Single beat, K=2, LANES=8, dist={9,3,7,3,12,1,5,8}, all lanes unmasked, in_last=1 → out_dist={1,3}, out_addr={5,1}, out_count=2, out_valid exactly 2 cycles after the accepting edge.
- Tie-break across beats: beat0 dist all 4; beat1 lane0=4, rest 9; last=1 → out_addr={0,1}, out_dist={4,4}.
- Mask/empty: beat0 in_mask=8'b0000_0100 with lane2=6, last=1 → out_count=1, out_dist[0]=6, out_addr[0]=2, out_dist[1]=8'hFF, out_addr[1]=0. A fully masked frame → out_count=0.
- Backpressure: hold out_ready=0 for 10 cycles → out_* stable and in_ready=0 throughout. Assert out_ready=1 → in_ready=1 next cycle, and the next frame's result is independent of the previous frame.
- Overflow: IDX_W=4, LANES=8, 3 beats, beat2 lane0=0 (others 200), last=1 → out_ovf=1, out_addr[0]=0 (wrapped index 16 mod 16), out_dist[0]=0.
- Reset mid-frame: drive rst=0 between two beats, release, then send the single-beat frame from the first scenario → no spurious out_valid before that frame; result as in the first scenario.
